// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Architectural constants shared by the MIPS datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
endpackage

`default_nettype wire

// File: rtl/sb_pending.sv
// ============================================================================
// Module      : sb_pending
// Description : Per-register pending-write scoreboard with set-over-clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_pending
    import mips_pkg::REG_ZERO;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_en_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    output logic [NUM_REGS-1:0] pend_o,
    output logic                pend_any_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // A new reservation replaces a completing producer on the same register.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_addr_i] = 1'b1;
        end
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o     = pend_q;
    assign pend_any_o = |pend_q;

endmodule

`default_nettype wire

// File: rtl/banco_registros_sb.sv
// ============================================================================
// Module      : banco_registros_sb
// Description : Multi-read register bank with write bypass and pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_registros_sb
    import mips_pkg::REG_ZERO;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     pend_any
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend;
    logic                w_wr_live;

    assign w_wr_live = wr_en && (wr_addr != c_zero_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (w_wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    sb_pending #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb_pending (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (rsv_en && (rsv_addr != c_zero_addr)),
        .set_addr_i (rsv_addr),
        .clr_en_i   (wr_en),
        .clr_addr_i (wr_addr),
        .pend_o     (w_pend),
        .pend_any_o (pend_any)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_valid;

        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Bypass is suppressed under reset so reads show the cleared file.
        always_comb begin
            w_data  = regs_q[w_addr];
            w_valid = !w_pend[w_addr];
            if (w_addr == c_zero_addr) begin
                w_data  = '0;
                w_valid = 1'b1;
            end else if ((BYPASS != 0) && !rst && wr_en && (wr_addr == w_addr)) begin
                w_data  = wr_data;
                w_valid = 1'b1;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
        assign rd_valid[i]                 = w_valid;
    end

endmodule

`default_nettype wire

// File: tb/tb_banco_registros_sb.sv
// ============================================================================
// Module      : tb_banco_registros_sb
// Description : Directed plus random checks of two bank configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banco_registros_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_valid_a;
    logic        pend_any_a;
    logic [19:0] rd_addr_b;
    logic [127:0] rd_data_b;
    logic [3:0]  rd_valid_b;
    logic        pend_any_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    banco_registros_sb u_dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_any(pend_any_a)
    );

    banco_registros_sb #(.NUM_RD(4), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_any(pend_any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && !rst && wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_valid(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd1;
        if (byp && !rst && wr_en && wr_addr == a) return 32'd1;
        return m_pend[a] ? 32'd0 : 32'd1;
    endfunction

    function automatic logic [31:0] m_pend_any();
        for (int r = 0; r < 32; r++) if (m_pend[r]) return 32'd1;
        return 32'd0;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = 32'd0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] a;
        for (int i = 0; i < 2; i++) begin
            a = rd_addr_a[i*5 +: 5];
            chk({tag, " A.data"},  rd_data_a[i*32 +: 32], m_data(a, 1'b1));
            chk({tag, " A.valid"}, {31'd0, rd_valid_a[i]}, m_valid(a, 1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            a = rd_addr_b[i*5 +: 5];
            chk({tag, " B.data"},  rd_data_b[i*32 +: 32], m_data(a, 1'b0));
            chk({tag, " B.valid"}, {31'd0, rd_valid_b[i]}, m_valid(a, 1'b0));
        end
        chk({tag, " A.pend_any"}, {31'd0, pend_any_a}, m_pend_any());
        chk({tag, " B.pend_any"}, {31'd0, pend_any_b}, m_pend_any());
    endtask

    // Advance one clock; the model commits what the inputs held at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] = wr_data;
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a);
        rd_addr_a = {2{a}};
        rd_addr_b = {4{a}};
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_rd(5'd0);
        m_clear();
        #2;
        check_all("reset_held");
        tick(); tick();
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a));
            #1;
            check_all("post_reset");
        end

        // Write with same-cycle read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5'd5);
        #2;
        chk("bypass5", rd_data_a[31:0], 32'hDEADBEEF);
        chk("nobyp5_old", rd_data_b[31:0], 32'd0);
        check_all("wr5");
        tick(); idle(); #2;
        chk("stored5", rd_data_a[31:0], 32'hDEADBEEF);
        check_all("rd5");

        // Register zero ignores writes and reservations
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0; set_rd(5'd0);
        tick(); idle(); #2;
        chk("zero_read", rd_data_a[31:0], 32'd0);
        chk("zero_pend", {31'd0, pend_any_a}, 32'd0);
        check_all("zero");

        // Reserve then complete
        rsv_en = 1'b1; rsv_addr = 5'd7; set_rd(5'd7);
        tick(); idle(); #2;
        chk("rsv7_valid", {31'd0, rd_valid_a[0]}, 32'd0);
        chk("rsv7_pend", {31'd0, pend_any_a}, 32'd1);
        check_all("rsv7");
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55; #2;
        chk("wr7_bypass_valid", {31'd0, rd_valid_a[0]}, 32'd1);
        chk("wr7_nobyp_valid", {31'd0, rd_valid_b[0]}, 32'd0);
        check_all("wr7");
        tick(); idle(); #2;
        chk("drain_pend", {31'd0, pend_any_a}, 32'd0);
        check_all("drain7");

        // Reserve and write the same register: reservation wins
        rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9;
        wr_data = 32'hCAFE0009; set_rd(5'd9);
        tick(); idle(); #2;
        chk("setwins_valid", {31'd0, rd_valid_a[0]}, 32'd0);
        chk("setwins_data", rd_data_a[31:0], 32'hCAFE0009);
        check_all("setwins");

        // Asynchronous reset mid-cycle drops in-flight write and reservation
        rsv_en = 1'b1; rsv_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd4;
        wr_data = 32'hA5; set_rd(5'd4);
        #1; rst = 1'b1; m_clear(); #1;
        chk("arst_data", rd_data_a[31:0], 32'd0);
        chk("arst_pend", {31'd0, pend_any_a}, 32'd0);
        check_all("arst");
        tick(); idle(); rst = 1'b0; #1;
        check_all("arst_after");

        // Random traffic, biased toward a few registers to create hazards
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data  = $urandom;
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            for (int i = 0; i < 2; i++)
                rd_addr_a[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 9));
            for (int i = 0; i < 4; i++)
                rd_addr_b[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 9));
            #2;
            check_all("rand");
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; m_clear(); #1;
                check_all("rand_arst");
                tick(); rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
